// File: rtl/mad_seq_pkg.sv
// Shared types and defaults for the iterative multiply-add unit.
// The counter width helper keeps a 1-bit counter when only one step is needed.
package mad_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mad_state_e;

    localparam int MAD_WIDTH          = 32;
    localparam int MAD_BITS_PER_CYCLE = 2;

    function automatic int mad_cnt_width(input int width, input int bits_per_cycle);
        int steps;
        steps = width / bits_per_cycle;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/mad_seq_if.sv
// Issue/result bundle between the issue FIFO head (master) and the multiply-add unit (slave).
// The FIFO holds input_valid high until result_valid pops the entry or the request is killed.
interface mad_seq_if
    import mad_seq_pkg::*;
#(
    parameter int WIDTH = MAD_WIDTH
);
    logic             input_valid;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] operand_c;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             busy_o;

    modport master (
        output input_valid, operand_a, operand_b, operand_c,
        input  result_valid, result, busy_o
    );

    modport slave (
        input  input_valid, operand_a, operand_b, operand_c,
        output result_valid, result, busy_o
    );
endinterface

// File: rtl/mad_pp_gen.sv
// Partial product a * b_slice truncated to WIDTH bits; purely combinational, no latency.
// No flow control: the caller decides when the product is consumed.
module mad_pp_gen
    import mad_seq_pkg::*;
#(
    parameter int WIDTH          = MAD_WIDTH,
    parameter int BITS_PER_CYCLE = MAD_BITS_PER_CYCLE
) (
    input  logic [WIDTH-1:0]          a,
    input  logic [BITS_PER_CYCLE-1:0] b_slice,
    output logic [WIDTH-1:0]          pp
);

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (b_slice[i]) begin
                pp = pp + (a << i);
            end
        end
    end

endmodule

// File: rtl/mad_seq_unit.sv
// Iterative (a*b + c) mod 2^WIDTH; latency N+1 cycles after acceptance, N = multiplier bits / BITS_PER_CYCLE.
// No backpressure on the result: result_valid is a one-cycle pulse that also pops the issue FIFO.
module mad_seq_unit
    import mad_seq_pkg::*;
#(
    parameter int WIDTH          = MAD_WIDTH,
    parameter int BITS_PER_CYCLE = MAD_BITS_PER_CYCLE
) (
    input  logic     clk_i,
    input  logic     rst_i,
    mad_seq_if.slave bus
);

    localparam int                CNT_W     = mad_cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam int                LAST_STEP = WIDTH / BITS_PER_CYCLE - 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LAST_STEP);

    mad_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] b_shifted;
    logic [WIDTH-1:0] acc_sum;
    logic             last_step;

    mad_pp_gen #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_gen (
        .a       (a_q),
        .b_slice (b_q[BITS_PER_CYCLE-1:0]),
        .pp      (pp)
    );

    // Early exit once no multiplier bits remain; the count limit bounds the worst case.
    assign b_shifted = b_q >> BITS_PER_CYCLE;
    assign acc_sum   = acc_q + pp;
    assign last_step = (b_shifted == '0) || (cnt_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.input_valid) begin
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    acc_d   = bus.operand_c;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A dropped request wins over completion in the same cycle.
                if (!bus.input_valid) begin
                    state_d = IDLE;
                end else begin
                    a_d   = a_q << BITS_PER_CYCLE;
                    b_d   = b_shifted;
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (last_step) begin
                        result_d = acc_sum;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.result_valid = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mad_seq_unit.sv
// Directed scenarios on a default-parameter unit, then a random sweep of BITS_PER_CYCLE = 1, 2, 4
// against an arithmetic reference (full-width product, latency from the multiplier's top set bit).
module tb_mad_seq_unit;
    import mad_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sweep_go = 1'b0;
    int   sweep_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mad_seq_if #(.WIDTH(32)) dif();

    mad_seq_unit #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (2)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif.slave)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mad(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        logic [63:0] full;
        full = 64'(a) * 64'(b) + 64'(c);
        return full[31:0];
    endfunction

    function automatic int ref_steps(input logic [31:0] b, input int bpc);
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + bpc) / bpc;
    endfunction

    // Called at a falling edge in an IDLE cycle (cycle 0); returns at the falling edge of DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] exp_res,
                          input int exp_cyc, input bit scramble);
        int cyc;
        cyc = -1;
        dif.input_valid = 1'b1;
        dif.operand_a   = a;
        dif.operand_b   = b;
        dif.operand_c   = c;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dif.result_valid) begin
                cyc = k;
                break;
            end
            check({tag, "_busy"}, dif.busy_o, 1);
            if (scramble) begin
                dif.operand_a = $urandom;
                dif.operand_b = $urandom;
                dif.operand_c = $urandom;
            end
        end
        check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_busy_done"}, dif.busy_o, 1);
        check({tag, "_result"}, dif.result, exp_res);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        mad_seq_if #(.WIDTH(32)) sif();

        mad_seq_unit #(
            .WIDTH          (32),
            .BITS_PER_CYCLE (BPC)
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (sif.slave)
        );

        initial begin : sweep
            logic [31:0] a, b, c, exp_r;
            int          n, kill_at;
            bit          b2b;
            string       tg;
            tg = $sformatf("bpc%0d", BPC);
            sif.input_valid = 1'b0;
            sif.operand_a   = '0;
            sif.operand_b   = '0;
            sif.operand_c   = '0;
            wait (sweep_go);
            @(negedge clk);
            for (int op = 0; op < 40; op++) begin
                a       = $urandom;
                b       = $urandom >> $urandom_range(0, 32);
                c       = $urandom;
                n       = ref_steps(b, BPC);
                exp_r   = ref_mad(a, b, c);
                kill_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, n)) : 0;
                sif.input_valid = 1'b1;
                sif.operand_a   = a;
                sif.operand_b   = b;
                sif.operand_c   = c;
                for (int k = 1; k <= n + 1; k++) begin
                    @(negedge clk);
                    if (k == n + 1) begin
                        check({tg, "_rv"}, sif.result_valid, 1);
                        check({tg, "_result"}, sif.result, exp_r);
                    end else begin
                        check({tg, "_busy_rv"}, sif.result_valid, 0);
                        check({tg, "_busy"}, sif.busy_o, 1);
                        if (k == kill_at) begin
                            sif.input_valid = 1'b0;
                            break;
                        end
                        sif.operand_a = $urandom;
                        sif.operand_b = $urandom;
                        sif.operand_c = $urandom;
                    end
                end
                if (kill_at != 0) begin
                    @(negedge clk);
                    check({tg, "_kill_busy"}, sif.busy_o, 0);
                    check({tg, "_kill_rv"}, sif.result_valid, 0);
                end else begin
                    b2b = 1'($urandom_range(0, 1));
                    if (!b2b) sif.input_valid = 1'b0;
                    @(negedge clk);
                    if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            sif.input_valid = 1'b0;
            sweep_done++;
        end
    end

    initial begin
        int pulses;
        rst = 1'b1;
        dif.input_valid = 1'b0;
        dif.operand_a   = '0;
        dif.operand_b   = '0;
        dif.operand_c   = '0;
        repeat (3) @(negedge clk);
        check("rst_rv", dif.result_valid, 0);
        check("rst_busy", dif.busy_o, 0);
        check("rst_result", dif.result, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic", 32'd3, 32'd5, 32'd7, 32'd22, 3, 1'b0);
        dif.input_valid = 1'b0;
        @(negedge clk);
        check("basic_idle_busy", dif.busy_o, 0);

        run_op("zero_b", 32'h1234, 32'h0, 32'hABCD, 32'hABCD, 2, 1'b0);
        dif.input_valid = 1'b0;
        @(negedge clk);

        run_op("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd3, 17, 1'b1);
        dif.input_valid = 1'b0;
        @(negedge clk);

        dif.input_valid = 1'b1;
        dif.operand_a   = 32'd9;
        dif.operand_b   = 32'hFFFF_0000;
        dif.operand_c   = 32'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("kill_rv", dif.result_valid, 0);
            if (k == 4) dif.input_valid = 1'b0;
        end
        @(negedge clk);
        check("kill_idle", dif.busy_o, 0);
        check("kill_idle_rv", dif.result_valid, 0);
        run_op("after_kill", 32'd2, 32'd2, 32'd0, 32'd4, 2, 1'b0);
        dif.input_valid = 1'b0;
        @(negedge clk);

        run_op("b2b1", 32'd1, 32'd1, 32'd1, 32'd2, 2, 1'b0);
        dif.operand_a = 32'd6;
        dif.operand_b = 32'd7;
        dif.operand_c = 32'd0;
        @(negedge clk);
        check("b2b_gap_rv", dif.result_valid, 0);
        run_op("b2b2", 32'd6, 32'd7, 32'd0, 32'd42, 3, 1'b1);
        dif.input_valid = 1'b0;
        @(negedge clk);

        dif.input_valid = 1'b1;
        dif.operand_a   = 32'd5;
        dif.operand_b   = 32'hFFFF_FFFF;
        dif.operand_c   = 32'd1;
        repeat (3) @(negedge clk);
        check("hold_result", dif.result, 42);
        check("pre_rst_busy", dif.busy_o, 1);
        rst = 1'b1;
        dif.input_valid = 1'b0;
        #1;
        check("mid_rst_rv", dif.result_valid, 0);
        check("mid_rst_busy", dif.busy_o, 0);
        check("mid_rst_result", dif.result, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (dif.result_valid) pulses++;
        end
        check("post_rst_pulses", pulses, 0);
        check("post_rst_busy", dif.busy_o, 0);

        sweep_go = 1'b1;
        for (int i = 0; i < 20000 && sweep_done < 3; i++) @(negedge clk);
        check("sweep_complete", sweep_done, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
